ysyx_25060173_ifu: RTL and testbench

Instruction fetch unit sitting directly upstream of the single-cycle core. Holds the architectural fetch PC, issues one read per instruction to instruction memory over a valid/ready request channel, and captures the response. Presents the instruction and its PC to the core with a valid/ready handshake, then waits for the core's retire redirect before fetching again. Strictly one instruction in flight; no prefetch, no prediction.

---
 rtl/ysyx_25060173_ifu.sv | 124 ++++++++++++
 tb/tb_ysyx_25060173_ifu.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_25060173_ifu.sv
// ysyx_25060173_ifu -- instruction fetch unit for the single-cycle core.
//
// Holds the architectural fetch PC and keeps exactly one instruction in
// flight: request -> response -> present to core -> wait for the retire
// redirect -> fetch again. No prefetch, no prediction.
//
// Ports
//   clk_i, reset_i            clock, synchronous active-high reset
//   mem_req_valid_o/ready_i   instruction memory request handshake
//   mem_req_addr_o            fetch address (current PC)
//   mem_rsp_valid_i           one response per accepted request
//   mem_rsp_data_i/err_i      instruction word / access fault
//   inst_valid_o/ready_i      instruction handshake towards the core
//   inst_o, inst_pc_o         instruction word and its PC
//   inst_fault_o              fetch faulted (inst_o forced to 0)
//   wb_valid_i, wb_next_pc_i  retire redirect from the core
//   fetch_cnt_o               instructions delivered (wrapping)
//
// Build option
//   YSYX_25060173_IFU_ALIGN_CHK_EN  when defined, a PC with pc[1:0]!=0 is
//   not sent to memory; the unit delivers a faulting zero instruction.
module ysyx_25060173_ifu #(
  parameter logic [31:0] RESET_PC = 32'h80000000
) (
  input  logic        clk_i,
  input  logic        reset_i,
  output logic        mem_req_valid_o,
  input  logic        mem_req_ready_i,
  output logic [31:0] mem_req_addr_o,
  input  logic        mem_rsp_valid_i,
  input  logic [31:0] mem_rsp_data_i,
  input  logic        mem_rsp_err_i,
  output logic        inst_valid_o,
  input  logic        inst_ready_i,
  output logic [31:0] inst_o,
  output logic [31:0] inst_pc_o,
  output logic        inst_fault_o,
  input  logic        wb_valid_i,
  input  logic [31:0] wb_next_pc_i,
  output logic [31:0] fetch_cnt_o
);

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_HOLD, S_EXEC} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q;
  logic [31:0] inst_q;
  logic [31:0] inst_pc_q;
  logic        inst_fault_q;
  logic [31:0] fetch_cnt_q;

  logic misalign;
  logic inst_hs;
  logic redirect;

`ifdef YSYX_25060173_IFU_ALIGN_CHK_EN
  assign misalign = (pc_q[1:0] != 2'b00);
`else
  assign misalign = 1'b0;
`endif

  assign inst_hs  = (state_q == S_HOLD) && inst_ready_i;
  // The redirect is only honoured at the delivery handshake or while the
  // core executes; everywhere else wb_valid_i is ignored.
  assign redirect = wb_valid_i && (inst_hs || (state_q == S_EXEC));

  // State register
  always_ff @(posedge clk_i) begin
    if (reset_i) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: state_d = S_REQ;
      S_REQ: begin
        if (misalign)             state_d = S_HOLD;
        else if (mem_req_ready_i) state_d = S_WAIT;
      end
      S_WAIT: if (mem_rsp_valid_i) state_d = S_HOLD;
      S_HOLD: if (inst_hs) state_d = wb_valid_i ? S_REQ : S_EXEC;
      S_EXEC: if (wb_valid_i) state_d = S_REQ;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs: decoded from registered state or taken straight from registers,
  // so nothing on an input reaches an output in the same cycle.
  always_comb begin
    mem_req_valid_o = (state_q == S_REQ) && !misalign;
    mem_req_addr_o  = pc_q;
    inst_valid_o    = (state_q == S_HOLD);
    inst_o          = inst_q;
    inst_pc_o       = inst_pc_q;
    inst_fault_o    = inst_fault_q;
    fetch_cnt_o     = fetch_cnt_q;
  end

  // Datapath registers
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      pc_q         <= RESET_PC;
      inst_q       <= 32'h0;
      inst_pc_q    <= RESET_PC;
      inst_fault_q <= 1'b0;
      fetch_cnt_q  <= 32'h0;
    end else begin
      if ((state_q == S_WAIT) && mem_rsp_valid_i) begin
        inst_q       <= mem_rsp_err_i ? 32'h0 : mem_rsp_data_i;
        inst_fault_q <= mem_rsp_err_i;
        inst_pc_q    <= pc_q;
      end else if ((state_q == S_REQ) && misalign) begin
        inst_q       <= 32'h0;
        inst_fault_q <= 1'b1;
        inst_pc_q    <= pc_q;
      end
      if (inst_hs)  fetch_cnt_q <= fetch_cnt_q + 32'd1;
      if (redirect) pc_q        <= wb_next_pc_i;
    end
  end

endmodule

// File: tb/tb_ysyx_25060173_ifu.sv
// Bench for ysyx_25060173_ifu: directed fetch transactions against a
// transaction-phase model of the fetch loop, plus literal spot checks.
module tb_ysyx_25060173_ifu;

  localparam logic [31:0] RESET_PC = 32'h80000000;
`ifdef YSYX_25060173_IFU_ALIGN_CHK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        mem_req_valid, mem_req_ready = 1'b0;
  logic [31:0] mem_req_addr;
  logic        mem_rsp_valid = 1'b0;
  logic [31:0] mem_rsp_data = 32'h0;
  logic        mem_rsp_err = 1'b0;
  logic        inst_valid, inst_ready = 1'b0;
  logic [31:0] inst, inst_pc;
  logic        inst_fault;
  logic        wb_valid = 1'b0;
  logic [31:0] wb_next_pc = 32'h0;
  logic [31:0] fetch_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  ysyx_25060173_ifu #(.RESET_PC(RESET_PC)) dut (
    .clk_i(clk), .reset_i(reset),
    .mem_req_valid_o(mem_req_valid), .mem_req_ready_i(mem_req_ready),
    .mem_req_addr_o(mem_req_addr),
    .mem_rsp_valid_i(mem_rsp_valid), .mem_rsp_data_i(mem_rsp_data),
    .mem_rsp_err_i(mem_rsp_err),
    .inst_valid_o(inst_valid), .inst_ready_i(inst_ready),
    .inst_o(inst), .inst_pc_o(inst_pc), .inst_fault_o(inst_fault),
    .wb_valid_i(wb_valid), .wb_next_pc_i(wb_next_pc),
    .fetch_cnt_o(fetch_cnt)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Model: which phase of the one-instruction loop we are in, the PC the
  // next fetch must use, the instruction the core should see, and the
  // delivered count.
  bit          m_start = 1'b1, m_req = 1'b0, m_mem = 1'b0, m_have = 1'b0, m_retire = 1'b0;
  logic [31:0] exp_pc = RESET_PC, exp_cnt = 32'h0;
  logic [31:0] e_inst = 32'h0, e_ipc = RESET_PC;
  logic        e_fault = 1'b0;

  always @(posedge clk) begin
    if (reset) begin
      m_start <= 1'b1; m_req <= 1'b0; m_mem <= 1'b0; m_have <= 1'b0; m_retire <= 1'b0;
      exp_pc <= RESET_PC; exp_cnt <= 32'h0;
      e_inst <= 32'h0; e_ipc <= RESET_PC; e_fault <= 1'b0;
    end else if (m_start) begin
      m_start <= 1'b0; m_req <= 1'b1;
    end else if (m_req) begin
      if (ALIGN && exp_pc[1:0] != 2'b00) begin
        m_req <= 1'b0; m_have <= 1'b1;
        e_inst <= 32'h0; e_fault <= 1'b1; e_ipc <= exp_pc;
      end else if (mem_req_ready) begin
        m_req <= 1'b0; m_mem <= 1'b1;
      end
    end else if (m_mem) begin
      if (mem_rsp_valid) begin
        m_mem <= 1'b0; m_have <= 1'b1;
        e_inst <= mem_rsp_err ? 32'h0 : mem_rsp_data;
        e_fault <= mem_rsp_err; e_ipc <= exp_pc;
      end
    end else if (m_have) begin
      if (inst_ready) begin
        m_have <= 1'b0;
        exp_cnt <= exp_cnt + 32'd1;
        if (wb_valid) begin exp_pc <= wb_next_pc; m_req <= 1'b1; end
        else m_retire <= 1'b1;
      end
    end else if (m_retire) begin
      if (wb_valid) begin m_retire <= 1'b0; exp_pc <= wb_next_pc; m_req <= 1'b1; end
    end
  end

  bit exp_req;
  always @(negedge clk) begin
    exp_req = m_req && !(ALIGN && exp_pc[1:0] != 2'b00);
    chk("m_req_valid", mem_req_valid, exp_req);
    if (exp_req) chk("m_req_addr", mem_req_addr, exp_pc);
    chk("m_inst_valid", inst_valid, m_have);
    if (m_have) begin
      chk("m_inst", inst, e_inst);
      chk("m_inst_pc", inst_pc, e_ipc);
      chk("m_inst_fault", inst_fault, e_fault);
    end
    chk("m_fetch_cnt", fetch_cnt, exp_cnt);
  end

  // One complete fetch starting from a negedge with a request pending.
  // Junk is driven on ignored inputs during stalls.
  task automatic do_fetch(input int req_stall, input int rsp_lat, input logic [31:0] data,
                          input logic err, input int hold_stall, input logic wb_same,
                          input logic [31:0] nxt, input logic [31:0] ipc);
    logic [31:0] want;
    want = err ? 32'h0 : data;
    chk("pre_req_valid", mem_req_valid, 1);
    for (int i = 0; i < req_stall; i++) begin
      mem_req_ready = 1'b0; wb_valid = 1'b1; wb_next_pc = 32'h12345678;
      mem_rsp_valid = 1'b1; mem_rsp_data = 32'hFFFFFFFF;
      @(negedge clk);
      chk("req_held", mem_req_valid, 1);
      chk("req_addr_stable", mem_req_addr, ipc);
    end
    wb_valid = 1'b0; mem_rsp_valid = 1'b0; mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0;
    chk("wait_req_low", mem_req_valid, 0);
    chk("wait_inst_low", inst_valid, 0);
    for (int i = 1; i < rsp_lat; i++) begin
      wb_valid = 1'b1; wb_next_pc = 32'hCAFE0000;
      @(negedge clk);
    end
    wb_valid = 1'b0;
    mem_rsp_valid = 1'b1; mem_rsp_data = data; mem_rsp_err = err;
    @(negedge clk);
    mem_rsp_valid = 1'b0; mem_rsp_err = 1'b0;
    chk("hold_valid", inst_valid, 1);
    chk("hold_inst", inst, want);
    chk("hold_pc", inst_pc, ipc);
    chk("hold_fault", inst_fault, err);
    for (int i = 0; i < hold_stall; i++) begin
      inst_ready = 1'b0; wb_valid = 1'b1; wb_next_pc = 32'h0BADF00D;
      @(negedge clk);
      chk("stall_valid", inst_valid, 1);
      chk("stall_inst", inst, want);
      chk("stall_pc", inst_pc, ipc);
    end
    inst_ready = 1'b1; wb_valid = wb_same; wb_next_pc = nxt;
    @(negedge clk);
    inst_ready = 1'b0; wb_valid = 1'b0;
    chk("post_hs_valid", inst_valid, 0);
    if (!wb_same) begin
      chk("exec_no_req", mem_req_valid, 0);
      @(negedge clk);
      chk("exec_no_req2", mem_req_valid, 0);
      wb_valid = 1'b1; wb_next_pc = nxt;
      @(negedge clk);
      wb_valid = 1'b0;
    end
    if (ALIGN && nxt[1:0] != 2'b00) chk("redir_suppressed", mem_req_valid, 0);
    else begin
      chk("redir_req", mem_req_valid, 1);
      chk("redir_addr", mem_req_addr, nxt);
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_req_valid", mem_req_valid, 0);
    chk("rst_req_addr", mem_req_addr, 32'h80000000);
    chk("rst_inst_valid", inst_valid, 0);
    chk("rst_inst", inst, 32'h0);
    chk("rst_inst_pc", inst_pc, 32'h80000000);
    chk("rst_fault", inst_fault, 0);
    chk("rst_cnt", fetch_cnt, 32'h0);
    reset = 1'b0;
    @(negedge clk);
    chk("first_req", mem_req_valid, 1);
    chk("first_addr", mem_req_addr, 32'h80000000);

    // basic fetch, same-cycle handshake + redirect
    do_fetch(0, 1, 32'h00100073, 1'b0, 0, 1'b1, 32'h80000004, 32'h80000000);
    chk("cnt_after_1", fetch_cnt, 32'd1);
    // memory back-pressure and core stall
    do_fetch(5, 1, 32'h00000013, 1'b0, 3, 1'b1, 32'h80000010, 32'h80000004);
    chk("cnt_after_2", fetch_cnt, 32'd2);
    // faulting response, redirect from EXEC
    do_fetch(0, 2, 32'hDEADBEEF, 1'b1, 0, 1'b0, 32'h80000020, 32'h80000010);
    // next fetch clears the fault
    do_fetch(0, 1, 32'h00A00093, 1'b0, 1, 1'b1, 32'h80000024, 32'h80000020);
    chk("cnt_after_4", fetch_cnt, 32'd4);

    // reset while waiting for a response; the stale response is dropped
    mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0; mem_rsp_valid = 1'b1; mem_rsp_data = 32'hBAD0BAD0;
    @(negedge clk);
    chk("stale_inst_valid", inst_valid, 0);
    chk("stale_req", mem_req_valid, 1);
    chk("stale_addr", mem_req_addr, 32'h80000000);
    chk("stale_cnt", fetch_cnt, 32'h0);
    @(negedge clk);
    mem_rsp_valid = 1'b0;
    chk("stale_inst_valid2", inst_valid, 0);

    // redirect to a misaligned PC
    do_fetch(0, 1, 32'h00000297, 1'b0, 0, 1'b1, 32'h80000002, 32'h80000000);
`ifdef YSYX_25060173_IFU_ALIGN_CHK_EN
    @(negedge clk);
    chk("mis_valid", inst_valid, 1);
    chk("mis_fault", inst_fault, 1);
    chk("mis_inst", inst, 32'h0);
    chk("mis_pc", inst_pc, 32'h80000002);
`else
    do_fetch(0, 1, 32'h00000517, 1'b0, 0, 1'b1, 32'h80000100, 32'h80000002);
    chk("cnt_after_mis", fetch_cnt, 32'd2);
`endif
    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
